// File: rtl/mmio_pkg.sv
// Address-map constants and decode helpers shared by the MMIO I/O bridge.
package mmio_pkg;

  localparam logic [15:0] DEF_IO_BASE = 16'hCFFD;
  localparam int unsigned IN_OFS      = 0;

  function automatic int unsigned out_ofs(input int unsigned n_in);
    return IN_OFS + n_in;
  endfunction

  function automatic int unsigned status_ofs(input int unsigned n_in, input int unsigned n_out);
    return IN_OFS + n_in + n_out;
  endfunction

  // True when the window offset lands on IN, OUT or STATUS; everything above reads 0.
  function automatic logic ofs_valid(input longint unsigned ofs, input int unsigned n_in,
                                     input int unsigned n_out);
    return ofs <= 64'(status_ofs(n_in, n_out));
  endfunction

endpackage

// File: rtl/mmio_sync_edge.sv
// Input synchroniser (STAGES flops) plus, with MMIO_IRQ_EN, a history flop
// that raises chg_o while the synchronised value differs from last cycle's.
module mmio_sync_edge #(
  parameter int unsigned W      = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o,
  output logic         chg_o
);

  logic [W-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= async_i;
      for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign sync_o = stage_q[STAGES-1];

`ifdef MMIO_IRQ_EN
  logic [W-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= '0;
    else       prev_q <= sync_o;
  end

  assign chg_o = (sync_o != prev_q);
`else
  assign chg_o = 1'b0;
`endif

endmodule

// File: rtl/mmio_io_bridge.sv
// CPU/RAM-port-A I/O bridge: gates RAM writes in the I/O window, returns I/O reads with RAM timing.
// Optional MMIO_IRQ_EN builds change-detect pending bits, W1C STATUS and the irq output.
module mmio_io_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] IO_BASE     = ADDR_W'(DEF_IO_BASE),
  parameter int unsigned       N_IN        = 2,
  parameter int unsigned       N_OUT       = 2,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic                    cpu_wren,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    ram_wren,
  input  logic [DATA_W-1:0]       ram_q,
  input  logic [N_IN*DATA_W-1:0]  in_ports,
  output logic [N_OUT*DATA_W-1:0] out_ports,
  output logic                    irq
);

  localparam int unsigned     OUT_OFS    = out_ofs(N_IN);
  localparam int unsigned     STATUS_OFS = status_ofs(N_IN, N_OUT);
  localparam longint unsigned ADDR_MAX   = (64'd1 << ADDR_W) - 64'd1;

  if ((64'(IO_BASE) + 64'(N_IN) + 64'(N_OUT) > ADDR_MAX) || N_IN < 1 || N_IN > 8 ||
      N_OUT < 1 || N_OUT > 8 || SYNC_STAGES < 2) begin : g_cfg_check
    $error("mmio_io_bridge: illegal configuration or I/O map overruns the address space");
  end

  logic                   io_hit;
  logic [ADDR_W-1:0]      ofs;
  logic [DATA_W-1:0]      in_sync [N_IN];
  logic [N_IN-1:0]        in_chg;
  logic [DATA_W-1:0]      out_d   [N_OUT];
  logic [DATA_W-1:0]      out_q   [N_OUT];
  logic [DATA_W-1:0]      io_rdata_d;
  logic [DATA_W-1:0]      io_rdata_q;
  logic                   io_hit_q;

  assign io_hit    = (cpu_addr >= IO_BASE);
  assign ofs       = cpu_addr - IO_BASE;
  assign ram_wren  = cpu_wren & ~io_hit;
  assign cpu_rdata = io_hit_q ? io_rdata_q : ram_q;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    mmio_sync_edge #(.W(DATA_W), .STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (in_ports[i*DATA_W +: DATA_W]),
      .sync_o  (in_sync[i]),
      .chg_o   (in_chg[i])
    );
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    assign out_ports[j*DATA_W +: DATA_W] = out_q[j];
  end

`ifdef MMIO_IRQ_EN
  logic [N_IN-1:0] pend_q, pend_d, pend_clr;
  logic            irq_q;

  assign pend_clr = (cpu_wren && io_hit && ofs == ADDR_W'(STATUS_OFS)) ? cpu_wdata[N_IN-1:0] : '0;
  // A change pulse in the same cycle as a clear re-arms the bit.
  assign pend_d   = (pend_q & ~pend_clr) | in_chg;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_q  <= |pend_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_chg;
  assign unused_chg = ^in_chg;
  assign irq        = 1'b0;
`endif

  // Read value comes from pre-write register contents, giving old-data read-during-write.
  always_comb begin
    io_rdata_d = '0;
    for (int j = 0; j < N_OUT; j++) out_d[j] = out_q[j];
    if (io_hit && ofs_valid(64'(ofs), N_IN, N_OUT)) begin
      for (int i = 0; i < N_IN; i++) begin
        if (ofs == ADDR_W'(IN_OFS + i)) io_rdata_d = in_sync[i];
      end
      for (int j = 0; j < N_OUT; j++) begin
        if (ofs == ADDR_W'(OUT_OFS + j)) begin
          io_rdata_d = out_q[j];
          if (cpu_wren) out_d[j] = cpu_wdata;
        end
      end
`ifdef MMIO_IRQ_EN
      if (ofs == ADDR_W'(STATUS_OFS)) io_rdata_d = DATA_W'(pend_q);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      io_hit_q   <= 1'b0;
      io_rdata_q <= '0;
      for (int j = 0; j < N_OUT; j++) out_q[j] <= '0;
    end else begin
      io_hit_q   <= io_hit;
      io_rdata_q <= io_rdata_d;
      for (int j = 0; j < N_OUT; j++) out_q[j] <= out_d[j];
    end
  end

endmodule
